// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// State/instruction sequencer for a multicycle processor. It holds the current
// state code, the instruction register and the memory data register, stalls
// on pending memory accesses, and traps illegal opcodes or reserved state
// codes into an absorbing HALT state.
//
// Ports
//   clk          in   1   sole clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   NS           in   4   next-state code from the main controller
//   IRWrite      in   1   load request for the instruction register
//   MemRead      in   1   memory read strobe (stall detection only)
//   MemWrite     in   1   memory write strobe (stall detection only)
//   MemData      in  32   read data from memory
//   mem_ready    in   1   memory access completes this cycle
//   S            out  4   current state code
//   Op           out  6   Instr[31:26]
//   Instr        out 32   instruction register
//   MDR          out 32   memory data register
//   stall        out  1   memory access pending
//   halted       out  1   in HALT
//   illegal      out  1   sticky illegal opcode / state code flag
//   cycle_count  out 32   cycles spent outside HALT
//   instr_count  out 32   instructions retired
//
// Configuration
//   INSTR_SEQ_PERF_COUNT_EN  when defined, the two performance counters are
//                            implemented; otherwise both ports read 0.
// -----------------------------------------------------------------------------
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  NS,
  input  logic        IRWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemData,
  input  logic        mem_ready,
  output logic [3:0]  S,
  output logic [5:0]  Op,
  output logic [31:0] Instr,
  output logic [31:0] MDR,
  output logic        stall,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  // Only the codes the sequencer itself interprets are named; every other
  // code is passed through from the controller.
  typedef enum logic [3:0] {
    ST_FETCH  = 4'h0,
    ST_DECODE = 4'h1,
    ST_HALT   = 4'hF
  } state_t;

  state_t      r_s;
  state_t      w_s_next;
  logic [31:0] r_instr;
  logic [31:0] r_mdr;
  logic        r_illegal;
  logic        w_illegal_set;
  logic        w_halted;
  logic        w_stall;
  logic        w_op_legal;
  logic        w_advance;

  assign w_halted  = (r_s == ST_HALT);
  assign w_stall   = (MemRead | MemWrite) & ~mem_ready & ~w_halted;
  assign w_advance = ~w_stall & ~w_halted;

  always_comb begin
    case (r_instr[31:26])
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: w_op_legal = 1'b1;
      default:                                               w_op_legal = 1'b0;
    endcase
  end

  // Next-state logic. A stall (or HALT) freezes the state, so an illegal
  // opcode seen in decode only traps on the first non-stalled edge.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_s_next      = r_s;
    w_illegal_set = 1'b0;
    if (w_advance) begin
      if (r_s == ST_DECODE && !w_op_legal) begin
        w_s_next      = ST_HALT;
        w_illegal_set = 1'b1;
      end else if (NS >= 4'd10 && NS <= 4'd14) begin
        // Codes 10..14 are reserved; the controller must never issue them.
        w_s_next      = ST_HALT;
        w_illegal_set = 1'b1;
      end else begin
        w_s_next = state_t'(NS);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s       <= ST_FETCH;
      r_instr   <= '0;
      r_mdr     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_s       <= w_s_next;
      r_illegal <= r_illegal | w_illegal_set;
      if (IRWrite && w_advance) r_instr <= MemData;
      if (w_advance)            r_mdr   <= MemData;
    end
  end

`ifdef INSTR_SEQ_PERF_COUNT_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;

  // An instruction retires when the state returns to fetch from any other
  // state; a stall never produces that transition because S holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (!w_halted) r_cycle_count <= r_cycle_count + 32'd1;
      if (r_s != ST_FETCH && w_s_next == ST_FETCH)
        r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

  assign S       = r_s;
  assign Op      = r_instr[31:26];
  assign Instr   = r_instr;
  assign MDR     = r_mdr;
  assign stall   = w_stall;
  assign halted  = w_halted;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed self-checking bench for instr_sequencer. A small multicycle
// controller model produces NS/IRWrite/MemRead/MemWrite from the current state
// code; override knobs let the stimulus force reserved state codes and extra
// memory strobes. Counter expectations follow INSTR_SEQ_PERF_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  NS;
  logic        IRWrite;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemData;
  logic        mem_ready;
  logic [3:0]  S;
  logic [5:0]  Op;
  logic [31:0] Instr;
  logic [31:0] MDR;
  logic        stall;
  logic        halted;
  logic        illegal;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  logic        force_en;
  logic [3:0]  force_ns;
  logic        force_rd;
  logic [3:0]  ns_ctrl;

  int errors = 0;
  int checks = 0;

`ifdef INSTR_SEQ_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .NS          (NS),
    .IRWrite     (IRWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemData     (MemData),
    .mem_ready   (mem_ready),
    .S           (S),
    .Op          (Op),
    .Instr       (Instr),
    .MDR         (MDR),
    .stall       (stall),
    .halted      (halted),
    .illegal     (illegal),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Classic multicycle controller: fetch, decode, then per-opcode paths.
  always_comb begin
    ns_ctrl = 4'd0;
    case (S)
      4'd0: ns_ctrl = 4'd1;
      4'd1: begin
        case (Op)
          6'b100011, 6'b101011: ns_ctrl = 4'd2;
          6'b000000:            ns_ctrl = 4'd6;
          6'b000100:            ns_ctrl = 4'd8;
          6'b000010:            ns_ctrl = 4'd9;
          default:              ns_ctrl = 4'd0;
        endcase
      end
      4'd2:    ns_ctrl = (Op == 6'b100011) ? 4'd3 : 4'd5;
      4'd3:    ns_ctrl = 4'd4;
      4'd6:    ns_ctrl = 4'd7;
      default: ns_ctrl = 4'd0;
    endcase
  end

  assign NS       = force_en ? force_ns : ns_ctrl;
  assign IRWrite  = (S == 4'd0);
  assign MemRead  = (S == 4'd0) || (S == 4'd3) || force_rd;
  assign MemWrite = (S == 4'd5);

  function automatic logic [31:0] cnt(input logic [31:0] v);
    return PERF ? v : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int          lw_seq [5] = '{1, 2, 3, 4, 0};
  logic [31:0] op_code [3] = '{32'hAC010000, 32'h10000000, 32'h08000000};
  int          op_next [3] = '{2, 8, 9};

  initial begin
    reset     = 1'b1;
    MemData   = 32'h0;
    mem_ready = 1'b1;
    force_en  = 1'b0;
    force_ns  = 4'h0;
    force_rd  = 1'b0;

    // Reset state before any clock edge.
    #2;
    check("rst_S", S, 0);
    check("rst_Instr", Instr, 0);
    check("rst_MDR", MDR, 0);
    check("rst_illegal", illegal, 0);
    check("rst_halted", halted, 0);
    check("rst_cyc", cycle_count, 0);
    check("rst_ins", instr_count, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;

    // lw through the full path: 0,1,2,3,4,0.
    MemData = 32'h8C220004;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("lw_S%0d", i), S, lw_seq[i]);
      if (i == 0) check("lw_Op", Op, 6'b100011);
    end
    check("lw_Op_end", Op, 6'b100011);
    check("lw_MDR", MDR, 32'h8C220004);
    check("lw_ins", instr_count, cnt(1));
    check("lw_cyc", cycle_count, cnt(5));
    check("lw_illegal", illegal, 0);

    // Fetch with three wait cycles.
    MemData   = 32'h014B4820;
    mem_ready = 1'b0;
    #1 check("st_stall_on", stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("st_S%0d", i), S, 0);
      check($sformatf("st_Instr%0d", i), Instr, 32'h8C220004);
      check($sformatf("st_stall%0d", i), stall, 1);
    end
    mem_ready = 1'b1;
    #1 check("st_stall_off", stall, 0);
    tick();
    check("st_S_load", S, 1);
    check("st_Instr_load", Instr, 32'h014B4820);
    check("st_Op", Op, 6'b000000);
    tick(); check("r_S6", S, 6);
    tick(); check("r_S7", S, 7);
    tick(); check("r_S0", S, 0);
    check("r_ins", instr_count, cnt(2));
    check("r_cyc", cycle_count, cnt(12));

    // Illegal opcode; a stall in decode delays the trap by one edge.
    MemData = 32'hFC000000;
    tick();
    check("ill_S1", S, 1);
    check("ill_Op", Op, 6'h3F);
    force_rd  = 1'b1;
    mem_ready = 1'b0;
    #1 check("ill_stall", stall, 1);
    tick();
    check("ill_S_hold", S, 1);
    check("ill_flag_early", illegal, 0);
    force_rd  = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("ill_S_halt", S, 4'hF);
    check("ill_flag", illegal, 1);
    check("ill_halted", halted, 1);
    force_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      MemData   = $urandom;
      tick();
    end
    mem_ready = 1'b0;
    #1;
    check("halt_S", S, 4'hF);
    check("halt_Instr", Instr, 32'hFC000000);
    check("halt_MDR", MDR, 32'hFC000000);
    check("halt_halted", halted, 1);
    check("halt_illegal", illegal, 1);
    check("halt_no_stall", stall, 0);
    check("halt_cyc", cycle_count, cnt(15));
    check("halt_ins", instr_count, cnt(2));
    force_rd = 1'b0;

    // Reset exits HALT.
    reset = 1'b1;
    #1;
    check("rst2_S", S, 0);
    check("rst2_illegal", illegal, 0);
    check("rst2_halted", halted, 0);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b1;

    // Remaining legal opcodes decode without trapping.
    for (int k = 0; k < 3; k++) begin
      MemData = op_code[k];
      tick();
      check($sformatf("op%0d_S1", k), S, 1);
      tick();
      check($sformatf("op%0d_dec", k), S, op_next[k]);
      check($sformatf("op%0d_illegal", k), illegal, 0);
      for (int j = 0; j < 4 && S != 4'd0; j++) tick();
      check($sformatf("op%0d_ret", k), S, 0);
    end

    // Reserved code 14 traps.
    force_en = 1'b1;
    force_ns = 4'hE;
    tick();
    check("ns14_S", S, 4'hF);
    check("ns14_illegal", illegal, 1);
    force_en = 1'b0;

    // Reserved code 11 forced from state 6.
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    MemData = 32'h014B4820;
    tick(); check("ns11_S1", S, 1);
    tick(); check("ns11_S6", S, 6);
    force_en = 1'b1;
    force_ns = 4'hB;
    tick();
    check("ns11_S", S, 4'hF);
    check("ns11_illegal", illegal, 1);
    force_en = 1'b0;

    // Asynchronous reset in the middle of a stall in state 3.
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    MemData = 32'h8C220004;
    tick(); tick(); tick();
    check("ar_S3", S, 3);
    mem_ready = 1'b0;
    #1 check("ar_stall", stall, 1);
    tick();
    check("ar_S3_hold", S, 3);
    check("ar_Instr", Instr, 32'h8C220004);
    check("ar_cyc_pre", cycle_count, cnt(4));
    #2 reset = 1'b1;
    #1;
    check("ar_S", S, 0);
    check("ar_Instr0", Instr, 0);
    check("ar_MDR0", MDR, 0);
    check("ar_cyc", cycle_count, 0);
    check("ar_ins", instr_count, 0);
    check("ar_illegal", illegal, 0);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b1;
    MemData   = 32'h014B4820;

    // Five R-type instructions back to back.
    for (int i = 0; i < 20; i++) tick();
    check("perf_S", S, 0);
    check("perf_ins", instr_count, cnt(5));
    check("perf_cyc", cycle_count, cnt(20));
    check("perf_illegal", illegal, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
